matrix_scan_arbiter: RTL and testbench

- Shares the 4x4 LED matrix between two players' 16-bit frame sources.
- Round-robin request/grant arbitration, with a hold period measured in whole frames.
- Latches the owner's frame at each frame boundary and scans the matrix row by row.
- Blanks the columns for one cycle at each row change to suppress ghosting.
- Sits between the per-player frame generators and the matrix pins.

---
 rtl/matrix_scan_arbiter.sv | 141 ++++++++++++++
 tb/tb_matrix_scan_arbiter.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/matrix_scan_arbiter.sv
// Two-player round-robin owner of a 4x4 LED matrix: arbitrates on frame boundaries,
// latches the owner's frame and scans it row by row with a one-cycle column blank per row.
module matrix_scan_arbiter #(
   parameter int DWELL_CYCLES = 1024,
   parameter int HOLD_FRAMES  = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_p1,
   input  logic [15:0] frame_p1,
   input  logic        req_p2,
   input  logic [15:0] frame_p2,
   output logic        gnt_p1,
   output logic        gnt_p2,
   output logic [3:0]  row,
   output logic [3:0]  col,
   output logic        frame_done
);

   localparam int DW = $clog2(DWELL_CYCLES);
   localparam int FW = (HOLD_FRAMES > 1) ? $clog2(HOLD_FRAMES) : 1;
   localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL_CYCLES - 1);
   localparam logic [FW-1:0] HOLD_LAST  = FW'(HOLD_FRAMES - 1);

   typedef enum logic [1:0] {
      IDLE,
      LOAD,
      SCAN
   } state_t;

   state_t         state;
   logic           last_grant;   // 1 = player 2 was granted last
   logic [15:0]    frame_buf;
   logic [DW-1:0]  dwell;
   logic [1:0]     row_idx;
   logic [FW-1:0]  frame_cnt;

   logic           win_valid;
   logic           win_p2;
   logic           owner_req;
   logic [15:0]    owner_frame;
   logic           dwell_end;
   logic           frame_end;
   logic           rearb;

   // Winner selection and frame-boundary decode; these only ever feed registers.
   always_comb begin
      win_valid   = req_p1 | req_p2;
      win_p2      = req_p2 & (~req_p1 | ~last_grant);
      owner_req   = gnt_p2 ? req_p2 : req_p1;
      owner_frame = gnt_p2 ? frame_p2 : frame_p1;
      dwell_end   = (dwell == DWELL_LAST);
      frame_end   = dwell_end && (row_idx == 2'd3);
      rearb       = frame_end && ((frame_cnt == HOLD_LAST) || !owner_req);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         gnt_p1     <= 1'b0;
         gnt_p2     <= 1'b0;
         last_grant <= 1'b1;
         frame_buf  <= '0;
         dwell      <= '0;
         row_idx    <= '0;
         frame_cnt  <= '0;
         row        <= '0;
         col        <= '0;
         frame_done <= 1'b0;
      end else begin
         // NOTE: non-blocking throughout, so every branch reads the pre-edge values.
         frame_done <= 1'b0;
         case (state)
            IDLE: begin
               row <= '0;
               col <= '0;
               if (win_valid) begin
                  gnt_p1     <= ~win_p2;
                  gnt_p2     <= win_p2;
                  last_grant <= win_p2;
                  state      <= LOAD;
               end
            end

            LOAD: begin
               frame_buf <= owner_frame;
               dwell     <= '0;
               row_idx   <= '0;
               frame_cnt <= '0;
               row       <= 4'b0001;
               col       <= '0;
               state     <= SCAN;
            end

            SCAN: begin
               if (!dwell_end) begin
                  dwell <= dwell + 1'b1;
                  col   <= frame_buf[{row_idx, 2'b00} +: 4];
               end else if (!frame_end) begin
                  dwell   <= '0;
                  row_idx <= row_idx + 2'd1;
                  row     <= 4'b0001 << (row_idx + 2'd1);
                  col     <= '0;
               end else begin
                  frame_done <= 1'b1;
                  dwell      <= '0;
                  row_idx    <= '0;
                  col        <= '0;
                  if (rearb) begin
                     frame_cnt <= '0;
                     row       <= '0;
                     if (win_valid) begin
                        gnt_p1     <= ~win_p2;
                        gnt_p2     <= win_p2;
                        last_grant <= win_p2;
                        state      <= LOAD;
                     end else begin
                        gnt_p1 <= 1'b0;
                        gnt_p2 <= 1'b0;
                        state  <= IDLE;
                     end
                  end else begin
                     frame_cnt <= frame_cnt + 1'b1;
                     frame_buf <= owner_frame;
                     row       <= 4'b0001;
                  end
               end
            end

            default: begin
               state  <= IDLE;
               gnt_p1 <= 1'b0;
               gnt_p2 <= 1'b0;
               row    <= '0;
               col    <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_matrix_scan_arbiter.sv
// Directed bench for matrix_scan_arbiter with DWELL_CYCLES=4, HOLD_FRAMES=2.
// Inputs change and outputs are sampled on the falling edge.
module tb_matrix_scan_arbiter;

   logic        clk;
   logic        rst;
   logic        req_p1;
   logic [15:0] frame_p1;
   logic        req_p2;
   logic [15:0] frame_p2;
   logic        gnt_p1;
   logic        gnt_p2;
   logic [3:0]  row;
   logic [3:0]  col;
   logic        frame_done;

   int n_total = 0;
   int n_bad   = 0;

   matrix_scan_arbiter #(
      .DWELL_CYCLES(4),
      .HOLD_FRAMES (2)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .req_p1    (req_p1),
      .frame_p1  (frame_p1),
      .req_p2    (req_p2),
      .frame_p2  (frame_p2),
      .gnt_p1    (gnt_p1),
      .gnt_p2    (gnt_p2),
      .row       (row),
      .col       (col),
      .frame_done(frame_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Gnt_p1, gnt_p2, row, col, frame_done packed for one-shot all-quiet checks.
   function automatic logic [15:0] outs();
      return {5'd0, gnt_p1, gnt_p2, row, col, frame_done};
   endfunction

   task automatic do_reset();
      rst = 1'b1;
      repeat (2) @(negedge clk);
      check("reset_outs", outs(), 16'h0000);
      rst = 1'b0;
   endtask

   // Checks one full 16-cycle SCAN frame showing 'shown'; optionally drops req_p1
   // (drop=1) or loads new_p1 into frame_p1 (drop=0) right after cycle evt_at.
   task automatic run_frame(input string tag, input logic [15:0] shown,
                            input logic g1, input logic g2, input logic done0,
                            input int evt_at, input logic drop, input logic [15:0] new_p1);
      logic [3:0] exp_row;
      logic [3:0] exp_col;
      for (int i = 0; i < 16; i++) begin
         @(negedge clk);
         exp_row = 4'b0001 << (i / 4);
         exp_col = ((i % 4) == 0) ? 4'b0000 : shown[(i / 4) * 4 +: 4];
         check($sformatf("%s c%0d row", tag, i), {12'd0, row}, {12'd0, exp_row});
         check($sformatf("%s c%0d col", tag, i), {12'd0, col}, {12'd0, exp_col});
         check($sformatf("%s c%0d done", tag, i), {15'd0, frame_done},
               {15'd0, (i == 0) ? done0 : 1'b0});
         check($sformatf("%s c%0d gnt", tag, i), {14'd0, gnt_p1, gnt_p2}, {14'd0, g1, g2});
         if (i == evt_at) begin
            if (drop) req_p1 = 1'b0;
            else      frame_p1 = new_p1;
         end
      end
   endtask

   // LOAD cycle: row/col blank, grant as given, frame_done as given.
   task automatic check_load(input string tag, input logic g1, input logic g2, input logic done);
      @(negedge clk);
      check(tag, outs(), {5'd0, g1, g2, 4'b0000, 4'b0000, done});
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      req_p1   = 1'b0;
      req_p2   = 1'b0;
      frame_p1 = 16'h0000;
      frame_p2 = 16'h0000;

      // Idle: nothing requested for 50 cycles.
      do_reset();
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         check($sformatf("idle c%0d", i), outs(), 16'h0000);
      end

      // Single requester: two held frames, then re-grant to the same player.
      req_p1   = 1'b1;
      frame_p1 = 16'h8421;
      check_load("solo load", 1'b1, 1'b0, 1'b0);
      run_frame("solo f0", 16'h8421, 1'b1, 1'b0, 1'b0, -1, 1'b0, 16'h0000);
      run_frame("solo f1", 16'h8421, 1'b1, 1'b0, 1'b1, -1, 1'b0, 16'h0000);
      check_load("solo regrant", 1'b1, 1'b0, 1'b1);
      run_frame("solo f2", 16'h8421, 1'b1, 1'b0, 1'b0, -1, 1'b0, 16'h0000);

      // Both requesting from reset: p1 first, p2 after two frames.
      req_p1   = 1'b1;
      req_p2   = 1'b1;
      frame_p1 = 16'h8421;
      frame_p2 = 16'hFFFF;
      do_reset();
      check_load("rr load p1", 1'b1, 1'b0, 1'b0);
      run_frame("rr p1 f0", 16'h8421, 1'b1, 1'b0, 1'b0, -1, 1'b0, 16'h0000);
      run_frame("rr p1 f1", 16'h8421, 1'b1, 1'b0, 1'b1, -1, 1'b0, 16'h0000);
      check_load("rr load p2", 1'b0, 1'b1, 1'b1);
      run_frame("rr p2 f0", 16'hFFFF, 1'b0, 1'b1, 1'b0, -1, 1'b0, 16'h0000);

      // Owner drops its request in row 1: frame completes, then IDLE.
      req_p1   = 1'b1;
      req_p2   = 1'b0;
      frame_p1 = 16'h8421;
      do_reset();
      check_load("drop load", 1'b1, 1'b0, 1'b0);
      run_frame("drop f0", 16'h8421, 1'b1, 1'b0, 1'b0, 5, 1'b1, 16'h0000);
      @(negedge clk);
      check("drop boundary", outs(), {5'd0, 1'b0, 1'b0, 4'b0000, 4'b0000, 1'b1});
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check($sformatf("drop idle c%0d", i), outs(), 16'h0000);
      end

      // Frame changes during row 2: only visible from the next frame.
      req_p1   = 1'b1;
      frame_p1 = 16'h8421;
      do_reset();
      check_load("chg load", 1'b1, 1'b0, 1'b0);
      run_frame("chg f0", 16'h8421, 1'b1, 1'b0, 1'b0, 8, 1'b0, 16'h000F);
      run_frame("chg f1", 16'h000F, 1'b1, 1'b0, 1'b1, -1, 1'b0, 16'h0000);

      // Asynchronous reset mid-row, then p2 alone is granted.
      req_p1   = 1'b1;
      frame_p1 = 16'h8421;
      do_reset();
      check_load("arst load", 1'b1, 1'b0, 1'b0);
      repeat (6) @(negedge clk);
      check("arst pre col", {12'd0, col}, 16'h0002);
      @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      check("arst immediate", outs(), 16'h0000);
      req_p1   = 1'b0;
      req_p2   = 1'b1;
      frame_p2 = 16'h5A3C;
      @(negedge clk);
      check("arst held", outs(), 16'h0000);
      rst = 1'b0;
      check_load("arst load p2", 1'b0, 1'b1, 1'b0);
      run_frame("arst p2 f0", 16'h5A3C, 1'b0, 1'b1, 1'b0, -1, 1'b0, 16'h0000);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
